bus_fifo: RTL and testbench

- Parametrised valid/ready buffering stage between a master and a slave.
- Successor to the single-register bus stage.
- Generalises data width and buffering depth.
- Adds occupancy and almost-full status, plus a completed-transfer counter.
- Decouples master-side backpressure from slave_ready, so the master never sees a combinational path from the slave.

---
 rtl/bus_fifo.sv | 83 ++++++++
 tb/tb_bus_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo.sv
// First-word-fall-through valid/ready buffer between a master and a slave.
// Tracks occupancy, almost-full status and a count of words delivered to the slave.
module bus_fifo #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic [DATA_W-1:0]        master_data,
  input  logic                     master_valid,
  output logic                     bus_ready,
  output logic [DATA_W-1:0]        bus_data,
  output logic                     bus_valid,
  input  logic                     slave_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic [CNT_W-1:0]         xfer_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic              push, pop;

  // Backpressure comes only from registered occupancy, never from slave_ready.
  assign bus_ready   = (level_q < LvlW'(DEPTH));
  assign bus_valid   = (level_q != '0);
  assign bus_data    = bus_valid ? mem_q[rd_ptr_q] : '0;
  assign almost_full = (level_q >= LvlW'(AF_LEVEL));
  assign level       = level_q;
  assign xfer_cnt    = xfer_cnt_q;

  assign push = master_valid && bus_ready;
  assign pop  = bus_valid && slave_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    level_d    = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Storage needs no reset; bus_data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= master_data;
    end
  end

endmodule

// File: tb/tb_bus_fifo.sv
// Bench for bus_fifo: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized master/slave traffic.
module tb_bus_fifo;

  localparam int unsigned DATA_W   = 24;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AF_LEVEL = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] md;
  logic              mv;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_data;
  logic              bus_valid;
  logic              sr;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic [CNT_W-1:0]  xfer_cnt;

  int errors = 0;
  int checks = 0;

  bus_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .RSTn        (rst_n),
    .master_data (md),
    .master_valid(mv),
    .bus_ready   (bus_ready),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .slave_ready (sr),
    .level       (level),
    .almost_full (almost_full),
    .xfer_cnt    (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words in flight plus a delivered count.
  logic [DATA_W-1:0] q[$];
  logic [CNT_W-1:0]  m_cnt = '0;
  bit                m_push = 1'b0;

  always @(posedge clk) begin
    bit do_pop;
    if (!rst_n) begin
      q.delete();
      m_cnt  = '0;
      m_push = 1'b0;
    end else begin
      m_push = mv && (q.size() < DEPTH);
      do_pop = sr && (q.size() != 0);
      if (do_pop) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (m_push) q.push_back(md);
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    m_cnt = '0;
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("cmp_valid", 32'(bus_valid), 32'(n != 0));
    chk("cmp_ready", 32'(bus_ready), 32'(n < DEPTH));
    chk("cmp_level", 32'(level), 32'(n));
    chk("cmp_af", 32'(almost_full), 32'(n >= AF_LEVEL));
    chk("cmp_cnt", 32'(xfer_cnt), 32'(m_cnt));
    chk("cmp_data", 32'(bus_data), (n != 0) ? 32'(q[0]) : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int sr_pct;
    rst_n = 1'b0;
    md    = '0;
    mv    = 1'b0;
    sr    = 1'b1;

    // 1: reset, then idle with slave ready
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("t1_valid", 32'(bus_valid), 32'd0);
      chk("t1_ready", 32'(bus_ready), 32'd1);
      chk("t1_level", 32'(level), 32'd0);
      chk("t1_cnt", 32'(xfer_cnt), 32'd0);
      chk("t1_data", 32'(bus_data), 32'd0);
      tick();
    end

    // 2: single word, one-cycle latency
    mv = 1'b1;
    md = 24'hA5A5A5;
    tick();
    mv = 1'b0;
    chk("t2_valid", 32'(bus_valid), 32'd1);
    chk("t2_data", 32'(bus_data), 32'hA5A5A5);
    chk("t2_level1", 32'(level), 32'd1);
    tick();
    chk("t2_level0", 32'(level), 32'd0);
    chk("t2_cnt", 32'(xfer_cnt), 32'd1);

    // 3: fill to full with slave stalled, then drain in order
    do_reset();
    sr = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      int lv;
      mv = 1'b1;
      md = DATA_W'(w);
      tick();
      lv = (w <= 4) ? w : 4;
      chk("t3_level", 32'(level), 32'(lv));
      chk("t3_af", 32'(almost_full), 32'(lv >= 3));
      chk("t3_ready", 32'(bus_ready), 32'(lv < 4));
    end
    sr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_out_valid", 32'(bus_valid), 32'd1);
      chk("t3_out", 32'(bus_data), 32'(i + 1));
      tick();
      if (i == 1) mv = 1'b0;
    end
    chk("t3_cnt", 32'(xfer_cnt), 32'd5);
    chk("t3_final", 32'(level), 32'd0);

    // 4: steady streaming at level 2 across two pointer wraps
    sr = 1'b0;
    mv = 1'b1;
    md = 24'h10;
    tick();
    md = 24'h11;
    tick();
    sr = 1'b1;
    md = 24'h12;
    for (int i = 0; i < 8; i++) begin
      chk("t4_level", 32'(level), 32'd2);
      chk("t4_ready", 32'(bus_ready), 32'd1);
      chk("t4_out", 32'(bus_data), 32'(24'h10 + i));
      tick();
      md = md + 1'b1;
    end
    chk("t4_level_end", 32'(level), 32'd2);
    chk("t4_out_end", 32'(bus_data), 32'h18);
    mv = 1'b0;
    tick();
    tick();
    chk("t4_cnt", 32'(xfer_cnt), 32'd15);

    // 5: full with push and pop requested together
    sr = 1'b0;
    mv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      md = DATA_W'(24'h20 + i);
      tick();
    end
    chk("t5_full", 32'(level), 32'd4);
    chk("t5_ready0", 32'(bus_ready), 32'd0);
    md = 24'h24;
    sr = 1'b1;
    tick();
    chk("t5_pop_only", 32'(level), 32'd3);
    chk("t5_data1", 32'(bus_data), 32'h21);
    tick();
    chk("t5_both", 32'(level), 32'd3);
    chk("t5_data2", 32'(bus_data), 32'h22);
    mv = 1'b0;
    sr = 1'b0;

    // 6: asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_cnt", 32'(xfer_cnt), 32'd0);
    chk("t6_ready", 32'(bus_ready), 32'd1);
    chk("t6_data", 32'(bus_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mv = 1'b1;
    md = 24'h123456;
    sr = 1'b1;
    tick();
    mv = 1'b0;
    chk("t6_new_valid", 32'(bus_valid), 32'd1);
    chk("t6_new_data", 32'(bus_data), 32'h123456);
    tick();
    chk("t6_new_level", 32'(level), 32'd0);
    chk("t6_new_cnt", 32'(xfer_cnt), 32'd1);

    // Random traffic; master holds its word until accepted.
    sr_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) sr_pct = (n / 200) % 3 == 0 ? 20 : ((n / 200) % 3 == 1 ? 90 : 50);
      if (!mv || m_push) begin
        mv = ($urandom_range(0, 3) != 0);
        md = DATA_W'($urandom);
      end
      sr = ($urandom_range(0, 99) < sr_pct);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
